// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings,
// default parameters and the round-robin pointer helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int DEFAULT_NUM_REQ      = 4;
  localparam int DEFAULT_BUSY_TIMEOUT = 16;

  // Index following idx, wrapping from n-1 back to 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set bit of pending at or above ptr,
// wrapping from NUM_REQ-1 to 0.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] idx_v;

  // Scan from the farthest offset down so the closest pending index wins last.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx_v       = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx_v = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (pending[idx_v]) begin
        grant_idx   = idx_v;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers, one buffered
// byte per producer, launched in round-robin order.
// Handshake: tx_send is a one-cycle launch pulse; the UART answers by raising
// tx_busy and the next launch waits until tx_busy is low again in IDLE. A UART
// that never shows busy is released after BUSY_TIMEOUT cycles in WAIT_BUSY.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEFAULT_NUM_REQ,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_send,
  output logic [NUM_REQ-1:0]   req_pending,
  output logic [NUM_REQ-1:0]   req_drop,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output arb_state_e           dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e       state;
  logic [7:0]       slot [NUM_REQ];
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             launch;
  logic [NUM_REQ-1:0] launch_vec;
  logic [CNT_W-1:0] cnt;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .pending     (req_pending),
    .ptr         (ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign launch    = (state == ST_IDLE) && grant_valid && !tx_busy;
  assign dbg_state = state;

  always_comb begin
    launch_vec = '0;
    if (launch) launch_vec[grant_idx] = 1'b1;
  end

  // A slot being launched this cycle is free, so a same-cycle send refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pending <= '0;
      req_drop    <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_drop[i] <= 1'b0;
        if (req_send[i]) begin
          if (!req_pending[i] || launch_vec[i]) begin
            slot[i]        <= req_data[8*i +: 8];
            req_pending[i] <= 1'b1;
          end else begin
            req_drop[i] <= 1'b1;
          end
        end else if (launch_vec[i]) begin
          req_pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      tx_data <= 8'h00;
      tx_send <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            tx_data <= slot[grant_idx];
            tx_send <= 1'b1;
            ptr     <= IDX_W'(rr_next(int'(grant_idx), NUM_REQ));
            state   <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) state <= ST_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed cycle-table bench for uart_tx_arbiter plus a busy-timeout sequence.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0] req_send;
  logic [NR-1:0] req_pending;
  logic [NR-1:0] req_drop;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_busy;
  arb_state_e    dbg_state;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_data    (req_data),
    .req_send    (req_send),
    .req_pending (req_pending),
    .req_drop    (req_drop),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_busy     (tx_busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NR-1:0] send;
    logic [31:0]   data;
    logic          busy;
    logic          exp_send;
    logic [7:0]    exp_data;
    logic [NR-1:0] exp_pend;
    logic [NR-1:0] exp_drop;
    arb_state_e    exp_state;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         row   = 0;

  function automatic vec_t v(logic r, logic [NR-1:0] s, logic [31:0] d, logic b,
                             logic es, logic [7:0] ed, logic [NR-1:0] ep,
                             logic [NR-1:0] edr, arb_state_e st);
    vec_t x;
    x.rst = r; x.send = s; x.data = d; x.busy = b;
    x.exp_send = es; x.exp_data = ed; x.exp_pend = ep; x.exp_drop = edr;
    x.exp_state = st;
    return x;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [NR-1:0] s, input logic [31:0] d, input logic b);
    rst = r; req_send = s; req_data = d; tx_busy = b;
  endtask

  initial begin
    int first;
    int second;
    int pulses;

    drive(1'b1, '0, '0, 1'b0);

    // reset
    tbl.push_back(v(1, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, ST_IDLE));
    // single byte from requester 2, 2-cycle latency
    tbl.push_back(v(0, 4'b0100, 32'h0007_0000, 0, 0, 8'h00, 4'b0100, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 1, 8'h07, 4'b0000, 4'b0000, ST_WAIT_BUSY));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'h07, 4'b0000, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'h07, 4'b0000, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 0, 8'h07, 4'b0000, 4'b0000, ST_IDLE));
    // reset to bring pointer back to 0, then all four at once
    tbl.push_back(v(1, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b1111, 32'hA3A2_A1A0, 0, 0, 8'h00, 4'b1111, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 1, 8'hA0, 4'b1110, 4'b0000, ST_WAIT_BUSY));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'hA0, 4'b1110, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'hA0, 4'b1110, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 0, 8'hA0, 4'b1110, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 1, 8'hA1, 4'b1100, 4'b0000, ST_WAIT_BUSY));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'hA1, 4'b1100, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 0, 8'hA1, 4'b1100, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 1, 8'hA2, 4'b1000, 4'b0000, ST_WAIT_BUSY));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'hA2, 4'b1000, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 0, 8'hA2, 4'b1000, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 1, 8'hA3, 4'b0000, 4'b0000, ST_WAIT_BUSY));
    // fairness: after granting 3, requesters 0 and 3 re-request; 0 goes first
    tbl.push_back(v(0, 4'b1001, 32'hB300_00B0, 1, 0, 8'hA3, 4'b1001, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 0, 8'hA3, 4'b1001, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 1, 8'hB0, 4'b1000, 4'b0000, ST_WAIT_BUSY));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'hB0, 4'b1000, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 0, 8'hB0, 4'b1000, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 1, 8'hB3, 4'b0000, 4'b0000, ST_WAIT_BUSY));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'hB3, 4'b0000, 4'b0000, ST_WAIT_DONE));
    // overflow on slot 1 while the UART is busy
    tbl.push_back(v(0, 4'b0010, 32'h0000_1100, 1, 0, 8'hB3, 4'b0010, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0010, 32'h0000_2200, 1, 0, 8'hB3, 4'b0010, 4'b0010, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'hB3, 4'b0010, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 0, 8'hB3, 4'b0010, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 1, 8'h11, 4'b0000, 4'b0000, ST_WAIT_BUSY));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'h11, 4'b0000, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 0, 8'h11, 4'b0000, 4'b0000, ST_IDLE));
    // same-cycle refill of slot 0 on its launch cycle
    tbl.push_back(v(0, 4'b0001, 32'h0000_0044, 0, 0, 8'h11, 4'b0001, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0001, 32'h0000_0055, 0, 1, 8'h44, 4'b0001, 4'b0000, ST_WAIT_BUSY));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'h44, 4'b0001, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 0, 8'h44, 4'b0001, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 1, 8'h55, 4'b0000, 4'b0000, ST_WAIT_BUSY));
    tbl.push_back(v(0, 4'b0000, 32'h0, 1, 0, 8'h55, 4'b0000, 4'b0000, ST_WAIT_DONE));
    // reset in WAIT_DONE with a byte buffered: everything cleared, byte discarded
    tbl.push_back(v(0, 4'b0100, 32'h0077_0000, 1, 0, 8'h55, 4'b0100, 4'b0000, ST_WAIT_DONE));
    tbl.push_back(v(1, 4'b0000, 32'h0, 1, 0, 8'h00, 4'b0000, 4'b0000, ST_IDLE));
    tbl.push_back(v(0, 4'b0000, 32'h0, 0, 0, 8'h00, 4'b0000, 4'b0000, ST_IDLE));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].send, tbl[i].data, tbl[i].busy);
      @(posedge clk);
      #1;
      row = i;
      check("tx_send", 32'(tx_send), 32'(tbl[i].exp_send));
      check("tx_data", 32'(tx_data), 32'(tbl[i].exp_data));
      check("req_pending", 32'(req_pending), 32'(tbl[i].exp_pend));
      check("req_drop", 32'(req_drop), 32'(tbl[i].exp_drop));
      check("state", 32'(dbg_state), 32'(tbl[i].exp_state));
    end

    // busy never rises: second launch follows BUSY_TIMEOUT+1 cycles after the first
    row = -1;
    @(negedge clk);
    drive(1'b0, 4'b0110, 32'h0032_3100, 1'b0);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    @(posedge clk);
    #1;
    check("to_capture", 32'(req_pending), 32'h6);
    @(negedge clk);
    req_send = '0;
    first  = -1;
    second = -1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      row = c;
      if (c == TO - 1) check("to_still_waiting", 32'(dbg_state), 32'(ST_WAIT_BUSY));
      if (c == TO)     check("to_back_idle", 32'(dbg_state), 32'(ST_IDLE));
      if (tx_send) begin
        pulses++;
        if (exp_q.size() == 0) check("to_extra_send", 32'(tx_data), 32'hFFFF_FFFF);
        else check("to_data", 32'(tx_data), 32'(exp_q.pop_front()));
        if (pulses == 1) first = c;
        else if (pulses == 2) second = c;
      end
    end
    check("to_first_cycle", 32'(first), 32'd0);
    check("to_gap", 32'(second - first), 32'(TO + 1));
    check("to_pulses", 32'(pulses), 32'd2);
    check("to_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
